// File: rtl/io_port_bank_pkg.sv
// Shared constants for the output port bank: status word bit positions and select sizing.
// No logic, no latency.
// No flow control; constants only.
package io_port_bank_pkg;

    localparam int IO_ST_EMPTY = 0;
    localparam int IO_ST_FULL  = 1;
    localparam int IO_ST_OVF   = 2;
    localparam int IO_ST_CNT   = 4;

    // A single channel still needs a 1-bit select so out-of-range writes can be expressed.
    function automatic int sel_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/io_fifo.sv
// One output channel: circular buffer with occupancy count and sticky overflow flag.
// Latency: push visible at head one cycle later; pop retires head at the handshake edge.
// Backpressure: pushes to a full buffer are dropped (flag set) unless a pop frees the slot that cycle.
module io_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_vld,
    input  logic [DATA_W-1:0] push_dat,
    input  logic              pop_rdy,
    input  logic              clr_ovf,
    output logic              pop_vld,
    output logic [DATA_W-1:0] pop_dat,
    output logic [CNT_W-1:0]  count,
    output logic              ovf
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic              full;
    logic              pop;
    logic              push_ok;

    assign full    = (count == FULL_CNT);
    assign pop_vld = (count != '0);
    assign pop     = pop_vld & pop_rdy;
    assign push_ok = push_vld & (~full | pop);
    assign pop_dat = pop_vld ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            if (push_ok && !pop)
                count <= count + CNT_W'(1);
            else if (pop && !push_ok)
                count <= count - CNT_W'(1);
            // A dropped push outranks a same-cycle clear so the loss is never hidden.
            if (push_vld && full && !pop)
                ovf <= 1'b1;
            else if (clr_ovf)
                ovf <= 1'b0;
        end
    end

    // Storage is deliberately unreset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (!reset && push_ok)
            mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/io_port_bank.sv
// Bank of independent output ports fed from the data bus, each draining over valid/ready.
// Latency: write to port_valid is 1 cycle; status reflects state after the last edge.
// Backpressure: per-channel buffering; writes to a full channel drop and set the sticky overflow.
module io_port_bank
    import io_port_bank_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int CHANNELS = 4,
    parameter int DEPTH    = 4,
    parameter int SEL_W    = sel_width(CHANNELS),
    parameter int CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         wr_en,
    input  logic [SEL_W-1:0]             wr_sel,
    input  logic [DATA_W-1:0]            wr_data,
    input  logic [SEL_W-1:0]             st_sel,
    input  logic                         clr_ovf,
    output logic [DATA_W-1:0]            status,
    output logic [CHANNELS*DATA_W-1:0]   port_data,
    output logic [CHANNELS-1:0]          port_valid,
    input  logic [CHANNELS-1:0]          port_ready
);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [CNT_W-1:0]    ch_count [CHANNELS];
    logic [CHANNELS-1:0] ch_ovf;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic push;
        logic clr;

        // Out-of-range selects match no channel, so those writes and clears vanish.
        assign push = wr_en   & (wr_sel == SEL_W'(i));
        assign clr  = clr_ovf & (st_sel == SEL_W'(i));

        io_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .CNT_W  (CNT_W)
        ) u_fifo (
            .clk      (clk),
            .reset    (reset),
            .push_vld (push),
            .push_dat (wr_data),
            .pop_rdy  (port_ready[i]),
            .clr_ovf  (clr),
            .pop_vld  (port_valid[i]),
            .pop_dat  (port_data[i*DATA_W +: DATA_W]),
            .count    (ch_count[i]),
            .ovf      (ch_ovf[i])
        );
    end

    always_comb begin
        status = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (st_sel == SEL_W'(i)) begin
                status[IO_ST_EMPTY]       = (ch_count[i] == '0);
                status[IO_ST_FULL]        = (ch_count[i] == FULL_CNT);
                status[IO_ST_OVF]         = ch_ovf[i];
                status[IO_ST_CNT +: CNT_W] = ch_count[i];
            end
        end
    end

endmodule

// File: tb/tb_io_port_bank.sv
// Self-checking bench for io_port_bank with five channels so that both in-range and out-of-range selects exist.
// Expected head values are queued per channel at write time and compared when the consumer pops them.
module tb_io_port_bank;
    localparam int CH  = 5;
    localparam int DW  = 8;
    localparam int DEP = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             wr_en;
    logic [2:0]       wr_sel;
    logic [DW-1:0]    wr_data;
    logic [2:0]       st_sel;
    logic             clr_ovf;
    logic [DW-1:0]    status;
    logic [CH*DW-1:0] port_data;
    logic [CH-1:0]    port_valid;
    logic [CH-1:0]    port_ready;

    always #5 clk = ~clk;

    io_port_bank #(
        .DATA_W   (DW),
        .CHANNELS (CH),
        .DEPTH    (DEP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_data    (wr_data),
        .st_sel     (st_sel),
        .clr_ovf    (clr_ovf),
        .status     (status),
        .port_data  (port_data),
        .port_valid (port_valid),
        .port_ready (port_ready)
    );

    int       checks   = 0;
    int       failures = 0;
    logic [7:0] sbq [CH][$];
    int       cnt   [CH];
    bit       ovf_m [CH];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] exp_status(input int ss);
        logic [7:0] s;
        s = 8'h00;
        if (ss >= CH) return s;
        s[0]   = (cnt[ss] == 0);
        s[1]   = (cnt[ss] == DEP);
        s[2]   = ovf_m[ss];
        s[6:4] = 3'(cnt[ss]);
        return s;
    endfunction

    // One clock: drive inputs, score pops against the queue, advance the model, then check outputs.
    task automatic cyc(input bit we, input int ws, input logic [7:0] wd, input logic [CH-1:0] rdy,
                       input bit clr, input int ss, input bit rst);
        bit         pop [CH];
        bit         ovf_set;
        logic [7:0] e;
        reset      = rst;
        wr_en      = we;
        wr_sel     = 3'(ws);
        wr_data    = wd;
        port_ready = rdy;
        clr_ovf    = clr;
        st_sel     = 3'(ss);
        #1;
        for (int i = 0; i < CH; i++) begin
            pop[i] = !rst && rdy[i] && (cnt[i] != 0);
            if (pop[i]) begin
                e = sbq[i].pop_front();
                chk($sformatf("pop_dat_ch%0d", i), 32'(port_data[i*DW +: DW]), 32'(e));
                cnt[i]--;
            end
        end
        ovf_set = 1'b0;
        if (!rst && we && ws < CH) begin
            if (cnt[ws] < DEP) begin
                sbq[ws].push_back(wd);
                cnt[ws]++;
            end else begin
                ovf_set = 1'b1;
            end
        end
        if (!rst && clr && ss < CH) ovf_m[ss] = 1'b0;
        if (ovf_set) ovf_m[ws] = 1'b1;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                cnt[i]   = 0;
                ovf_m[i] = 1'b0;
                sbq[i].delete();
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < CH; i++) begin
            chk($sformatf("valid_ch%0d", i), 32'(port_valid[i]), 32'(cnt[i] != 0));
            if (cnt[i] == 0)
                chk($sformatf("idle_dat_ch%0d", i), 32'(port_data[i*DW +: DW]), 32'h0);
        end
        chk($sformatf("status_sel%0d", ss), 32'(status), 32'(exp_status(ss)));
    endtask

    initial begin
        for (int i = 0; i < CH; i++) begin
            cnt[i]   = 0;
            ovf_m[i] = 1'b0;
        end

        cyc(0, 0, 8'h00, '0, 0, 0, 1);
        cyc(0, 0, 8'h00, '0, 0, 0, 1);
        chk("rst_valid", 32'(port_valid), 32'h0);
        chk("rst_data", 32'(port_data), 32'h0);

        for (int s = 0; s < 8; s++) begin
            cyc(0, 0, 8'h00, '0, 0, s, 0);
            chk($sformatf("idle_st%0d", s), 32'(status), (s < CH) ? 32'h01 : 32'h00);
        end

        cyc(1, 2, 8'hA5, '0, 0, 2, 0);
        chk("a5_valid", 32'(port_valid), 32'b00100);
        chk("a5_st", 32'(status), 32'h10);
        cyc(0, 0, 8'h00, 5'b00100, 0, 2, 0);
        chk("a5_popped", 32'(status), 32'h01);

        for (int k = 1; k <= 5; k++) cyc(1, 0, 8'(k * 8'h11), '0, 0, 0, 0);
        chk("ovf_st", 32'(status), 32'h46);
        for (int k = 0; k < 4; k++) cyc(0, 0, 8'h00, 5'b00001, 0, 0, 0);
        chk("drain_st", 32'(status), 32'h05);
        cyc(0, 0, 8'h00, '0, 1, 0, 0);
        chk("clr0_st", 32'(status), 32'h01);

        for (int k = 1; k <= 4; k++) cyc(1, 1, 8'(8'h60 + k), '0, 0, 1, 0);
        cyc(1, 1, 8'h99, 5'b00010, 0, 1, 0);
        chk("full_pushpop_st", 32'(status), 32'h42);
        for (int k = 0; k < 4; k++) cyc(0, 1, 8'h00, 5'b00010, 0, 1, 0);
        chk("ch1_drained", 32'(status), 32'h01);

        for (int k = 0; k < 5; k++) cyc(1, 3, 8'(8'h70 + k), '0, 0, 3, 0);
        chk("ch3_ovf", 32'(status), 32'h46);
        cyc(1, 3, 8'h7F, '0, 1, 3, 0);
        chk("clr_vs_set", 32'(status), 32'h46);
        cyc(0, 3, 8'h00, '0, 1, 3, 0);
        chk("clr_alone", 32'(status), 32'h42);
        for (int k = 0; k < 4; k++) cyc(0, 3, 8'h00, 5'b01000, 0, 3, 0);

        for (int k = 0; k < 10; k++) cyc(1, 0, 8'(8'hC0 + k), 5'b00001, 0, 0, 0);
        cyc(0, 0, 8'h00, 5'b00001, 0, 0, 0);
        chk("wrap_empty", 32'(status), 32'h01);

        cyc(1, 6, 8'hEE, '0, 0, 6, 0);
        chk("bad_sel_valid", 32'(port_valid), 32'h0);
        chk("bad_sel_st", 32'(status), 32'h0);

        for (int k = 0; k < 3; k++) cyc(1, 2, 8'(8'h30 + k), '0, 0, 2, 0);
        chk("pre_rst_st", 32'(status), 32'h30);
        cyc(1, 2, 8'h3F, 5'b00100, 0, 2, 1);
        chk("mid_rst_valid", 32'(port_valid), 32'h0);
        chk("mid_rst_st", 32'(status), 32'h01);
        cyc(0, 2, 8'h00, 5'b11111, 0, 2, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
